// File: rtl/avl_bus_n21_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avl_bus_n21_pkg
//  Description : Shared types and constants for the N-to-1 i_avl_bus arbiter:
//                arbiter state encoding, read-owner FIFO entry layout, burst
//                field width and a helper that normalises burst counts.
//  Contents    : AVL_BURST_W, AVL_ID_W, arb_state_t, avl_n21_fifo_entry_t,
//                burst_beats()
//  Revision    : 1.0 - initial release
// ============================================================================
package avl_bus_n21_pkg;

    // Width of the burst_count field on every i_avl_bus port.
    localparam int AVL_BURST_W = 8;
    // Master index width stored in the FIFO; sized for the 16-master maximum.
    localparam int AVL_ID_W    = 4;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_LOCK   = 2'd1,
        ARB_WBURST = 2'd2
    } arb_state_t;

    // One entry per accepted read: which master owns it and how many
    // response beats it will return.
    typedef struct packed {
        logic [AVL_ID_W-1:0]    id;
        logic [AVL_BURST_W-1:0] count;
    } avl_n21_fifo_entry_t;

    // A burst_count of 0 on a read still produces one response beat.
    function automatic logic [AVL_BURST_W-1:0] burst_beats(input logic [AVL_BURST_W-1:0] bc);
        return (bc == '0) ? AVL_BURST_W'(1) : bc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/avl_bus_n21_if.sv
`default_nettype none
// ============================================================================
//  Module      : i_avl_bus
//  Description : Request/response bundle of the i_avl_bus protocol.
//  Modports    : master - drives address, byte_en, read, write, write_data,
//                         begin_burst_transfer, burst_count, resp_ready;
//                         receives read_data, read_data_valid, request_ready
//                slave  - the mirror image of master
//  Revision    : 1.0 - initial release
// ============================================================================
interface i_avl_bus;

    logic [31:0]                            address;
    logic [3:0]                             byte_en;
    logic                                   read;
    logic                                   write;
    logic [31:0]                            write_data;
    logic                                   begin_burst_transfer;
    logic [avl_bus_n21_pkg::AVL_BURST_W-1:0] burst_count;
    logic                                   resp_ready;
    logic [31:0]                            read_data;
    logic                                   read_data_valid;
    logic                                   request_ready;

    modport master (
        output address, byte_en, read, write, write_data,
               begin_burst_transfer, burst_count, resp_ready,
        input  read_data, read_data_valid, request_ready
    );

    modport slave (
        input  address, byte_en, read, write, write_data,
               begin_burst_transfer, burst_count, resp_ready,
        output read_data, read_data_valid, request_ready
    );

endinterface
`default_nettype wire

// File: rtl/avl_bus_n21_fifo_sync.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_sync
//  Description : Single-clock FIFO, power-of-two depth, extra pointer bit to
//                tell full from empty. Pushes while full and pops while empty
//                are ignored.
//  Ports       : clk, rst (async, active-high), i_push, i_wr_data, i_pop,
//                o_rd_data (head, valid when !o_empty), o_full, o_empty
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wr_data,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rd_data,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push    = i_push & ~o_full;
    assign w_pop     = i_pop & ~o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/avl_bus_n21_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : avl_bus_n21_rr_arbiter
//  Description : Combinational round-robin priority encoder. Searches the
//                request vector upward from i_last_grant+1 with wrap-around.
//  Ports       : i_req        - one request bit per master
//                i_last_grant - index of the most recently served master
//                o_grant      - selected master (i_last_grant when idle)
//                o_any_req    - at least one request is pending
//  Revision    : 1.0 - initial release
// ============================================================================
module avl_bus_n21_rr_arbiter #(
    parameter int MASTER_NUM = 2,
    parameter int ID_WIDTH   = $clog2(MASTER_NUM)
) (
    input  wire logic [MASTER_NUM-1:0] i_req,
    input  wire logic [ID_WIDTH-1:0]   i_last_grant,
    output logic      [ID_WIDTH-1:0]   o_grant,
    output logic                       o_any_req
);

    logic [ID_WIDTH-1:0] w_idx;

    // Walk from the farthest candidate back to the nearest so the nearest
    // requester after i_last_grant is the one left in o_grant.
    always_comb begin
        o_grant   = i_last_grant;
        o_any_req = |i_req;
        w_idx     = '0;
        for (int k = MASTER_NUM; k >= 1; k--) begin
            w_idx = ID_WIDTH'((int'(i_last_grant) + k) % MASTER_NUM);
            if (i_req[w_idx]) o_grant = w_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/avl_bus_n21.sv
`default_nettype none
// ============================================================================
//  Module      : avl_bus_n21
//  Description : N-to-1 i_avl_bus arbiter. Round-robin grant with zero-latency
//                forwarding, grant lock while a request is stalled or a write
//                burst is in progress, and an in-order owner FIFO that routes
//                read responses back to the master that issued the read.
//  Ports       : clk     - clock
//                rest    - asynchronous active-high reset
//                avl_in  - MASTER_NUM master-facing bundles (slave modport)
//                avl_out - bundle toward the shared slave (master modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module avl_bus_n21
    import avl_bus_n21_pkg::*;
#(
    parameter int MASTER_NUM     = 2,
    parameter int SEL_FIFO_DEPTH = 4
) (
    input  wire logic clk,
    input  wire logic rest,
    i_avl_bus.slave   avl_in [MASTER_NUM],
    i_avl_bus.master  avl_out
);

    localparam int ID_WIDTH = $clog2(MASTER_NUM);
    localparam int FIFO_W   = $bits(avl_n21_fifo_entry_t);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [ID_WIDTH-1:0]    r_grant;
    logic [ID_WIDTH-1:0]    r_last_grant;
    logic [ID_WIDTH-1:0]    w_arb_grant;
    logic [ID_WIDTH-1:0]    w_grant;
    logic                   w_any_req;
    logic [AVL_BURST_W-1:0] r_wbeat;
    logic [AVL_BURST_W-1:0] r_rbeat;

    // Per-master copies of the interface fields, so they can be indexed by
    // the run-time grant.
    logic [MASTER_NUM-1:0]  w_rd;
    logic [MASTER_NUM-1:0]  w_wr;
    logic [MASTER_NUM-1:0]  w_req;
    logic [MASTER_NUM-1:0]  w_bbt;
    logic [MASTER_NUM-1:0]  w_resp_ready;
    logic [MASTER_NUM-1:0]  w_head_sel;
    logic [31:0]            w_addr  [MASTER_NUM];
    logic [3:0]             w_be    [MASTER_NUM];
    logic [31:0]            w_wdata [MASTER_NUM];
    logic [AVL_BURST_W-1:0] w_bc    [MASTER_NUM];

    logic                   w_run;
    logic                   w_rd_sel;
    logic                   w_wr_sel;
    logic                   w_req_sel;
    logic                   w_read_ok;
    logic                   w_fwd;
    logic                   w_accept;
    logic                   w_burst_start;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head_rdy;
    logic                   w_resp_hs;
    avl_n21_fifo_entry_t    w_push_entry;
    avl_n21_fifo_entry_t    w_head;

    // Outputs are forced low while reset is held, so a mid-transfer reset
    // silences both sides immediately rather than at the next edge.
    assign w_run = ~rest;

    generate
        for (genvar g = 0; g < MASTER_NUM; g++) begin : g_master
            assign w_rd[g]         = avl_in[g].read;
            assign w_wr[g]         = avl_in[g].write;
            assign w_req[g]        = avl_in[g].read | avl_in[g].write;
            assign w_bbt[g]        = avl_in[g].begin_burst_transfer;
            assign w_resp_ready[g] = avl_in[g].resp_ready;
            assign w_addr[g]       = avl_in[g].address;
            assign w_be[g]         = avl_in[g].byte_en;
            assign w_wdata[g]      = avl_in[g].write_data;
            assign w_bc[g]         = avl_in[g].burst_count;
            assign w_head_sel[g]   = ~w_fifo_empty & (w_head.id == AVL_ID_W'(g));

            assign avl_in[g].read_data       = avl_out.read_data;
            assign avl_in[g].request_ready   = w_run & avl_out.request_ready & w_fwd &
                                               (w_grant == ID_WIDTH'(g));
            assign avl_in[g].read_data_valid = w_run & w_head_sel[g] & avl_out.read_data_valid;
        end
    endgenerate

    avl_bus_n21_rr_arbiter #(
        .MASTER_NUM (MASTER_NUM),
        .ID_WIDTH   (ID_WIDTH)
    ) u_rr_arbiter (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_arb_grant),
        .o_any_req    (w_any_req)
    );

    // Fresh arbitration only in ARB_IDLE; otherwise the registered grant holds.
    assign w_grant   = (r_state == ARB_IDLE && w_any_req) ? w_arb_grant : r_grant;
    assign w_rd_sel  = w_rd[w_grant];
    assign w_wr_sel  = w_wr[w_grant];
    assign w_req_sel = w_rd_sel | w_wr_sel;

    // A full owner FIFO holds reads back; popping in the same cycle does not
    // free the slot early.
    assign w_read_ok     = w_rd_sel & ~w_fifo_full;
    assign w_fwd         = w_read_ok | w_wr_sel;
    assign w_accept      = w_fwd & avl_out.request_ready;
    assign w_burst_start = w_wr_sel & w_bbt[w_grant] & (w_bc[w_grant] > AVL_BURST_W'(1));

    assign avl_out.read                 = w_run & w_read_ok;
    assign avl_out.write                = w_run & w_wr_sel;
    assign avl_out.address              = w_addr[w_grant];
    assign avl_out.byte_en              = w_be[w_grant];
    assign avl_out.write_data           = w_wdata[w_grant];
    assign avl_out.begin_burst_transfer = w_bbt[w_grant];
    assign avl_out.burst_count          = w_bc[w_grant];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ARB_IDLE, ARB_LOCK: begin
                if (w_accept)
                    w_state_nxt = w_burst_start ? ARB_WBURST : ARB_IDLE;
                else if (w_req_sel)
                    w_state_nxt = ARB_LOCK;
                else
                    w_state_nxt = ARB_IDLE;
            end
            ARB_WBURST: begin
                if (w_accept && w_wr_sel && r_wbeat == AVL_BURST_W'(1))
                    w_state_nxt = ARB_IDLE;
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            r_state      <= ARB_IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_WIDTH'(MASTER_NUM - 1);
            r_wbeat      <= '0;
            r_rbeat      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant;
            if (w_accept) r_last_grant <= w_grant;

            // The first beat is accepted on entry, so burst_count-1 remain.
            if (r_state != ARB_WBURST && w_accept && w_burst_start)
                r_wbeat <= w_bc[w_grant] - AVL_BURST_W'(1);
            else if (r_state == ARB_WBURST && w_accept && w_wr_sel)
                r_wbeat <= r_wbeat - AVL_BURST_W'(1);

            if (w_pop)
                r_rbeat <= '0;
            else if (w_resp_hs)
                r_rbeat <= r_rbeat + AVL_BURST_W'(1);
        end
    end

    // Response routing follows the FIFO head; read_data is broadcast.
    assign w_head_rdy         = |(w_resp_ready & w_head_sel);
    assign avl_out.resp_ready = w_run & w_head_rdy;
    assign w_resp_hs          = avl_out.read_data_valid & w_head_rdy;
    assign w_pop              = w_resp_hs & (r_rbeat == w_head.count - AVL_BURST_W'(1));

    assign w_push             = w_accept & w_read_ok;
    assign w_push_entry.id    = AVL_ID_W'(w_grant);
    assign w_push_entry.count = burst_beats(w_bc[w_grant]);

    fifo_sync #(
        .WIDTH (FIFO_W),
        .DEPTH (SEL_FIFO_DEPTH)
    ) u_sel_fifo (
        .clk       (clk),
        .rst       (rest),
        .i_push    (w_push),
        .i_wr_data (w_push_entry),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_avl_bus_n21.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avl_bus_n21
//  Description : Directed self-checking bench for avl_bus_n21 with two
//                masters and a four-entry owner FIFO. The bench plays the
//                slave by hand, one cycle per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avl_bus_n21;

    logic clk = 1'b0;
    logic rest;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    i_avl_bus m_if [2] ();
    i_avl_bus s_if ();

    avl_bus_n21 #(
        .MASTER_NUM     (2),
        .SEL_FIFO_DEPTH (4)
    ) dut (
        .clk     (clk),
        .rest    (rest),
        .avl_in  (m_if),
        .avl_out (s_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 2 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m0(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [7:0] bc, input logic bbt);
        m_if[0].read                 = rd;
        m_if[0].write                = wr;
        m_if[0].address              = addr;
        m_if[0].write_data           = {addr[15:0], 16'h5A5A};
        m_if[0].byte_en              = 4'hF;
        m_if[0].burst_count          = bc;
        m_if[0].begin_burst_transfer = bbt;
    endtask

    task automatic m1(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [7:0] bc, input logic bbt);
        m_if[1].read                 = rd;
        m_if[1].write                = wr;
        m_if[1].address              = addr;
        m_if[1].write_data           = {addr[15:0], 16'hA5A5};
        m_if[1].byte_en              = 4'hF;
        m_if[1].burst_count          = bc;
        m_if[1].begin_burst_transfer = bbt;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rest = 1'b1;
        m0(1'b1, 1'b0, 32'h100, 8'd1, 1'b0);
        m1(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        m_if[0].resp_ready   = 1'b1;
        m_if[1].resp_ready   = 1'b1;
        s_if.request_ready   = 1'b1;
        s_if.read_data_valid = 1'b0;
        s_if.read_data       = 32'h0;

        // ---- reset: nothing forwarded even with a request present
        #3;
        chk("rst_out_read", s_if.read, 1'b0);
        chk("rst_rr0", m_if[0].request_ready, 1'b0);
        chk("rst_resp_ready", s_if.resp_ready, 1'b0);
        @(posedge clk);
        tick();
        rest = 1'b0;

        // ---- alternating single reads, responses one cycle later
        m1(1'b1, 1'b0, 32'h200, 8'd1, 1'b0);
        #2;
        chk("t1_addr_m0", s_if.address, 32'h100);
        chk("t1_rr0", m_if[0].request_ready, 1'b1);
        chk("t1_rr1", m_if[1].request_ready, 1'b0);
        tick();
        s_if.read_data_valid = 1'b1;
        s_if.read_data       = 32'hAAAA;
        #2;
        chk("t1_addr_m1", s_if.address, 32'h200);
        chk("t1_rdv0_a", m_if[0].read_data_valid, 1'b1);
        chk("t1_rdv1_a", m_if[1].read_data_valid, 1'b0);
        chk("t1_bcast", m_if[1].read_data, 32'hAAAA);
        tick();
        s_if.read_data = 32'hBBBB;
        #2;
        chk("t1_addr_m0b", s_if.address, 32'h100);
        chk("t1_rdv1_b", m_if[1].read_data_valid, 1'b1);
        chk("t1_rdv0_b", m_if[0].read_data_valid, 1'b0);
        tick();
        m0(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        m1(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        s_if.read_data = 32'hCCCC;
        #2;
        chk("t1_rdv0_c", m_if[0].read_data_valid, 1'b1);
        chk("t1_idle_read", s_if.read, 1'b0);
        tick();
        #2;
        chk("t1_empty_resp_ready", s_if.resp_ready, 1'b0);
        chk("t1_empty_rdv0", m_if[0].read_data_valid, 1'b0);
        chk("t1_empty_rdv1", m_if[1].read_data_valid, 1'b0);
        tick();
        s_if.read_data_valid = 1'b0;

        // ---- stalled read from master 1 keeps the grant
        m1(1'b1, 1'b0, 32'h200, 8'd1, 1'b0);
        s_if.request_ready = 1'b0;
        #2;
        chk("t2_addr_c1", s_if.address, 32'h200);
        chk("t2_rr1_stall", m_if[1].request_ready, 1'b0);
        tick();
        m0(1'b0, 1'b1, 32'h300, 8'd1, 1'b0);
        #2;
        chk("t2_addr_c2", s_if.address, 32'h200);
        chk("t2_no_write", s_if.write, 1'b0);
        tick();
        s_if.request_ready = 1'b1;
        #2;
        chk("t2_addr_c3", s_if.address, 32'h200);
        chk("t2_rr1", m_if[1].request_ready, 1'b1);
        chk("t2_rr0", m_if[0].request_ready, 1'b0);
        tick();
        m1(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        s_if.read_data_valid = 1'b1;
        s_if.read_data       = 32'hDDDD;
        #2;
        chk("t2_addr_m0", s_if.address, 32'h300);
        chk("t2_write", s_if.write, 1'b1);
        chk("t2_rr0_after", m_if[0].request_ready, 1'b1);
        chk("t2_rdv1", m_if[1].read_data_valid, 1'b1);
        tick();
        m0(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        s_if.read_data_valid = 1'b0;

        // ---- 4-beat write burst from master 0, master 1 waiting
        m0(1'b0, 1'b1, 32'h400, 8'd4, 1'b1);
        #2;
        chk("t3_b1_addr", s_if.address, 32'h400);
        chk("t3_b1_rr0", m_if[0].request_ready, 1'b1);
        tick();
        m1(1'b1, 1'b0, 32'h500, 8'd1, 1'b0);
        #2;
        chk("t3_b2_addr", s_if.address, 32'h400);
        chk("t3_b2_read", s_if.read, 1'b0);
        chk("t3_b2_rr1", m_if[1].request_ready, 1'b0);
        tick();
        #2;
        chk("t3_b3_wdata", s_if.write_data, 32'h04005A5A);
        chk("t3_b3_rr0", m_if[0].request_ready, 1'b1);
        tick();
        #2;
        chk("t3_b4_addr", s_if.address, 32'h400);
        chk("t3_b4_write", s_if.write, 1'b1);
        tick();
        m0(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        #2;
        chk("t3_m1_addr", s_if.address, 32'h500);
        chk("t3_m1_rr1", m_if[1].request_ready, 1'b1);
        tick();
        m1(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        s_if.read_data_valid = 1'b1;
        s_if.read_data       = 32'hEEEE;
        #2;
        chk("t3_rdv1", m_if[1].read_data_valid, 1'b1);
        tick();
        s_if.read_data_valid = 1'b0;

        // ---- owner FIFO fills: fifth read held until one cycle after a pop
        m0(1'b1, 1'b0, 32'h600, 8'd1, 1'b0);
        #2;
        chk("t4_rd1_rr0", m_if[0].request_ready, 1'b1);
        tick();
        tick();
        tick();
        #2;
        chk("t4_rd4_rr0", m_if[0].request_ready, 1'b1);
        tick();
        #2;
        chk("t4_full_rr0", m_if[0].request_ready, 1'b0);
        chk("t4_full_read", s_if.read, 1'b0);
        tick();
        s_if.read_data_valid = 1'b1;
        s_if.read_data       = 32'h1111;
        #2;
        chk("t4_pop_rr0", m_if[0].request_ready, 1'b0);
        chk("t4_pop_rdv0", m_if[0].read_data_valid, 1'b1);
        chk("t4_pop_resp_ready", s_if.resp_ready, 1'b1);
        tick();
        s_if.read_data_valid = 1'b0;
        #2;
        chk("t4_after_rr0", m_if[0].request_ready, 1'b1);
        chk("t4_after_read", s_if.read, 1'b1);
        tick();
        m0(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        s_if.read_data_valid = 1'b1;
        repeat (4) tick();
        #2;
        chk("t4_drained_resp_ready", s_if.resp_ready, 1'b0);
        chk("t4_drained_rdv0", m_if[0].read_data_valid, 1'b0);
        s_if.read_data_valid = 1'b0;
        tick();

        // ---- 3-beat read burst to master 1 with a stall, then master 0 read
        m1(1'b1, 1'b0, 32'h700, 8'd3, 1'b1);
        #2;
        chk("t5_rr1", m_if[1].request_ready, 1'b1);
        tick();
        m1(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        m0(1'b1, 1'b0, 32'h800, 8'd1, 1'b0);
        #2;
        chk("t5_addr_m0", s_if.address, 32'h800);
        chk("t5_rr0", m_if[0].request_ready, 1'b1);
        tick();
        m0(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        s_if.read_data_valid = 1'b1;
        s_if.read_data       = 32'h2001;
        #2;
        chk("t5_beat1_rdv1", m_if[1].read_data_valid, 1'b1);
        tick();
        m_if[1].resp_ready = 1'b0;
        s_if.read_data     = 32'h2002;
        #2;
        chk("t5_stall_resp_ready", s_if.resp_ready, 1'b0);
        chk("t5_stall_rdv0", m_if[0].read_data_valid, 1'b0);
        tick();
        m_if[1].resp_ready = 1'b1;
        #2;
        chk("t5_beat2_resp_ready", s_if.resp_ready, 1'b1);
        chk("t5_beat2_rdv1", m_if[1].read_data_valid, 1'b1);
        tick();
        s_if.read_data = 32'h2003;
        #2;
        chk("t5_beat3_rdv1", m_if[1].read_data_valid, 1'b1);
        tick();
        s_if.read_data = 32'h2004;
        #2;
        chk("t5_beat4_rdv0", m_if[0].read_data_valid, 1'b1);
        chk("t5_beat4_rdv1", m_if[1].read_data_valid, 1'b0);
        chk("t5_beat4_data", m_if[0].read_data, 32'h2004);
        tick();
        s_if.read_data_valid = 1'b0;

        // ---- reset during a write burst with two reads outstanding
        m1(1'b1, 1'b0, 32'h900, 8'd1, 1'b0);
        tick();
        m1(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        m0(1'b1, 1'b0, 32'hA00, 8'd1, 1'b0);
        tick();
        m0(1'b0, 1'b1, 32'hB00, 8'd4, 1'b1);
        #2;
        chk("t6_burst_write", s_if.write, 1'b1);
        tick();
        m1(1'b1, 1'b0, 32'h900, 8'd1, 1'b0);
        #2;
        chk("t6_burst_addr", s_if.address, 32'hB00);
        #1;
        rest                 = 1'b1;
        s_if.read_data_valid = 1'b1;
        #1;
        chk("t6_rst_write", s_if.write, 1'b0);
        chk("t6_rst_read", s_if.read, 1'b0);
        chk("t6_rst_rr0", m_if[0].request_ready, 1'b0);
        chk("t6_rst_rr1", m_if[1].request_ready, 1'b0);
        chk("t6_rst_resp_ready", s_if.resp_ready, 1'b0);
        chk("t6_rst_rdv0", m_if[0].read_data_valid, 1'b0);
        chk("t6_rst_rdv1", m_if[1].read_data_valid, 1'b0);
        tick();
        tick();
        rest = 1'b0;
        m0(1'b1, 1'b0, 32'hC00, 8'd1, 1'b0);
        #2;
        chk("t6_post_addr", s_if.address, 32'hC00);
        chk("t6_post_rr0", m_if[0].request_ready, 1'b1);
        chk("t6_post_rr1", m_if[1].request_ready, 1'b0);
        chk("t6_post_resp_ready", s_if.resp_ready, 1'b0);
        tick();
        m0(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        m1(1'b0, 1'b0, 32'h0, 8'd0, 1'b0);
        s_if.read_data_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
